// File: rtl/modbus_wr_frame_tx.sv
// Modbus RTU "Write Multiple Registers" request framer: header, mux-fetched register data, CRC-16.
// Optional MODBUS_TX_GAP_EN holds busy for a GAP_CYCLES inter-frame silence after each frame.
module modbus_wr_frame_tx #(
    parameter logic [7:0] FUNC_CODE   = 8'h10,
    parameter int         MAX_REGS    = 123,
    parameter int         MUX_LATENCY = 2
`ifdef MODBUS_TX_GAP_EN
    ,parameter int        GAP_CYCLES  = 1750
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  adr,
    input  logic [15:0] adr_first_reg_tx,
    input  logic [7:0]  num_reg_tx,
    input  logic [15:0] data_in,
    output logic [7:0]  selector,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_DATA_HI, S_DATA_LO, S_CRC_LO, S_CRC_HI, S_GAP
    } state_t;

    localparam logic [7:0] MAX_N  = 8'(MAX_REGS);
    localparam logic [1:0] LAT_M1 = 2'(MUX_LATENCY - 1);

    state_t      state, state_d;
    logic [7:0]  adr_q, num_q, k;
    logic [15:0] first_q, hold, crc;
    logic [2:0]  hdr_idx;
    logic [1:0]  wait_cnt;
    logic [7:0]  hdr_byte;
    logic        n_ok, xfer;
`ifdef MODBUS_TX_GAP_EN
    logic [31:0] gap_cnt;
`endif

    // One full reflected-0xA001 byte update per cycle.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign n_ok = (num_reg_tx != 8'd0) && (num_reg_tx <= MAX_N);
    assign xfer = tx_valid && tx_ready;
    assign busy = (state != S_IDLE);

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx)
            3'd0:    hdr_byte = adr_q;
            3'd1:    hdr_byte = FUNC_CODE;
            3'd2:    hdr_byte = first_q[15:8];
            3'd3:    hdr_byte = first_q[7:0];
            3'd4:    hdr_byte = 8'h00;
            3'd5:    hdr_byte = num_q;
            default: hdr_byte = {num_q[6:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d  = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_IDLE: if (start && n_ok) state_d = S_HDR;
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (tx_ready && hdr_idx == 3'd6) state_d = S_FETCH;
            end
            S_FETCH: if (wait_cnt == LAT_M1) state_d = S_DATA_HI;
            S_DATA_HI: begin
                tx_valid = 1'b1;
                tx_data  = hold[15:8];
                if (tx_ready) state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
                tx_valid = 1'b1;
                tx_data  = hold[7:0];
                if (tx_ready) state_d = (k == num_q) ? S_CRC_LO : S_FETCH;
            end
            S_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = crc[7:0];
                if (tx_ready) state_d = S_CRC_HI;
            end
            S_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = crc[15:8];
`ifdef MODBUS_TX_GAP_EN
                if (tx_ready) state_d = S_GAP;
`else
                if (tx_ready) state_d = S_IDLE;
`endif
            end
`ifdef MODBUS_TX_GAP_EN
            S_GAP: if (gap_cnt == 32'd0) state_d = S_IDLE;
`else
            S_GAP: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q    <= 8'h00;
            first_q  <= 16'h0000;
            num_q    <= 8'h00;
            k        <= 8'h00;
            hold     <= 16'h0000;
            crc      <= 16'hFFFF;
            hdr_idx  <= 3'd0;
            wait_cnt <= 2'd0;
            selector <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef MODBUS_TX_GAP_EN
            gap_cnt  <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE && start) begin
                if (n_ok) begin
                    adr_q   <= adr;
                    first_q <= adr_first_reg_tx;
                    num_q   <= num_reg_tx;
                    hdr_idx <= 3'd0;
                    crc     <= 16'hFFFF;
                end else begin
                    err <= 1'b1;
                end
            end
            // CRC covers header and data bytes only, never its own bytes.
            if (xfer && (state == S_HDR || state == S_DATA_HI || state == S_DATA_LO))
                crc <= crc16_byte(crc, tx_data);
            if (state == S_HDR && xfer) begin
                hdr_idx <= hdr_idx + 3'd1;
                if (hdr_idx == 3'd6) begin
                    k        <= 8'd1;
                    selector <= 8'd1;
                    wait_cnt <= 2'd0;
                end
            end
            if (state == S_FETCH) begin
                wait_cnt <= wait_cnt + 2'd1;
                if (wait_cnt == LAT_M1) hold <= data_in;
            end
            if (state == S_DATA_LO && xfer) begin
                if (k == num_q) begin
                    selector <= 8'h00;
                end else begin
                    k        <= k + 8'd1;
                    selector <= k + 8'd1;
                    wait_cnt <= 2'd0;
                end
            end
            if (state == S_CRC_HI && xfer) begin
                done <= 1'b1;
`ifdef MODBUS_TX_GAP_EN
                gap_cnt <= 32'(GAP_CYCLES - 1);
`endif
            end
`ifdef MODBUS_TX_GAP_EN
            if (state == S_GAP && gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_modbus_wr_frame_tx.sv
// Bench for modbus_wr_frame_tx: vector table, random frames against a frame/CRC model, corner sequences.
module tb_modbus_wr_frame_tx;

`ifdef MODBUS_TX_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, tx_ready = 1'b0;
    logic [7:0]  adr = 8'h00, num_reg_tx = 8'h00;
    logic [15:0] adr_first_reg_tx = 16'h0000, data_in = 16'h0000;
    logic [7:0]  selector, tx_data;
    logic        tx_valid, busy, done, err;

    always #5 clk = ~clk;

`ifdef MODBUS_TX_GAP_EN
    modbus_wr_frame_tx #(.GAP_CYCLES(10)) dut (
`else
    modbus_wr_frame_tx dut (
`endif
        .clk(clk), .reset(reset), .start(start), .adr(adr),
        .adr_first_reg_tx(adr_first_reg_tx), .num_reg_tx(num_reg_tx),
        .data_in(data_in), .selector(selector), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .err(err));

    // Register mux with one pipeline stage: selector change -> valid data two edges later.
    logic [15:0] mux_val [256];
    always @(posedge clk) data_in <= mux_val[selector];

    int n_chk = 0, n_fail = 0;
    int rdy_mode = 0, rcnt = 0;
    logic [7:0] cap[$], exp_q[$], sel_q[$];
    int done_cnt = 0, err_cnt = 0, stab_viol = 0, busy_seen = 0, valid_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (rcnt % 3 == 0);
            default: tx_ready = 1'($urandom % 2);
        endcase
        rcnt++;
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) cap.push_back(tx_data);
        if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_viol++;
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_seen++;
        if (tx_valid) valid_seen++;
        if (sel_q.size() > 0 && selector != sel_q[$]) sel_q.push_back(selector);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference frame: header fields, register values, then bitwise Modbus CRC over all of it.
    task automatic build_exp(input logic [7:0] a, input logic [15:0] f, input logic [7:0] n);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(a);
        exp_q.push_back(8'h10);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[7:0]);
        exp_q.push_back(8'h00);
        exp_q.push_back(n);
        exp_q.push_back(8'((2 * int'(n)) % 256));
        for (int i = 1; i <= int'(n); i++) begin
            exp_q.push_back(mux_val[i][15:8]);
            exp_q.push_back(mux_val[i][7:0]);
        end
        c = 16'hFFFF;
        foreach (exp_q[i]) begin
            c = c ^ {8'h00, exp_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [15:0] f, input logic [7:0] n,
                             input int mode, input bit mid, input string nm);
        bit got;
        int bad;
        build_exp(a, f, n);
        cap.delete();
        sel_q.delete();
        sel_q.push_back(8'h00);
        done_cnt = 0; err_cnt = 0; stab_viol = 0;
        rdy_mode = mode;
        @(posedge clk); #1;
        adr = a; adr_first_reg_tx = f; num_reg_tx = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        adr = 8'($urandom); adr_first_reg_tx = 16'($urandom); num_reg_tx = 8'($urandom);
        chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
        got = 1'b0;
        for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
            @(posedge clk); #1;
            start = mid && cyc == 40;
            if (mid && cyc == 40) num_reg_tx = 8'd4;
            if (done) begin
                got = 1'b1;
                chk({nm, "_busy_at_done"}, 32'(busy), 32'(GAP));
            end
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        for (int cyc = 0; cyc < 3000 && busy; cyc++) @(posedge clk);
        @(posedge clk); #1;
        bad = 0;
        if (cap.size() != exp_q.size()) bad++;
        else foreach (exp_q[i]) if (cap[i] !== exp_q[i]) bad++;
        chk({nm, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        chk({nm, "_byte_errs"}, 32'(bad), 32'd0);
        bad = 0;
        if (sel_q.size() != int'(n) + 2) bad++;
        else for (int i = 0; i < int'(n) + 2; i++)
            if (sel_q[i] != ((i <= int'(n)) ? 8'(i) : 8'h00)) bad++;
        chk({nm, "_sel_seq"}, 32'(bad), 32'd0);
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_no_err"}, 32'(err_cnt), 32'd0);
        chk({nm, "_stable"}, 32'(stab_viol), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [15:0] f;
        logic [7:0]  n;
        int          rmode;
        int          dmode;
        bit          mid;
        int          exp_len;
        logic [7:0]  exp_bc;
        bit          crc_known;
        logic [15:0] exp_crc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'h01, 16'h0001, 8'd2,   0, 0, 1'b0, 13,  8'h04, 1'b1, 16'h3092};
        tbl[1] = '{8'h01, 16'h0001, 8'd2,   1, 0, 1'b0, 13,  8'h04, 1'b1, 16'h3092};
        tbl[2] = '{8'hF7, 16'hABCD, 8'd1,   2, 2, 1'b0, 11,  8'h02, 1'b0, 16'h0000};
        tbl[3] = '{8'h22, 16'h0100, 8'd5,   0, 1, 1'b0, 19,  8'h0A, 1'b0, 16'h0000};
        tbl[4] = '{8'h01, 16'h0000, 8'd123, 0, 1, 1'b1, 255, 8'hF6, 1'b0, 16'h0000};
        for (int i = 0; i < 256; i++) mux_val[i] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_selector", 32'(selector), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        reset = 1'b0;

        foreach (tbl[t]) begin
            for (int i = 1; i <= 255; i++)
                mux_val[i] = (tbl[t].dmode == 1) ? 16'(i) : 16'($urandom);
            if (tbl[t].dmode == 0) begin
                mux_val[1] = 16'h000A;
                mux_val[2] = 16'h0102;
            end
            run_frame(tbl[t].a, tbl[t].f, tbl[t].n, tbl[t].rmode, tbl[t].mid, $sformatf("vec%0d", t));
            chk($sformatf("vec%0d_exp_len", t), 32'(cap.size()), 32'(tbl[t].exp_len));
            if (cap.size() > 6) chk($sformatf("vec%0d_bytecount", t), 32'(cap[6]), 32'(tbl[t].exp_bc));
            if (tbl[t].crc_known && cap.size() == 13)
                chk($sformatf("vec%0d_crc", t), {16'd0, cap[12], cap[11]}, {16'd0, tbl[t].exp_crc});
        end

        // Rejected starts: N=0 and N=MAX_REGS+1.
        rdy_mode = 0;
        err_cnt = 0; busy_seen = 0; valid_seen = 0;
        @(posedge clk); #1;
        num_reg_tx = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej0_err_pulse", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        num_reg_tx = 8'd124; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rej_err_cnt", 32'(err_cnt), 32'd2);
        chk("rej_busy_seen", 32'(busy_seen), 32'd0);
        chk("rej_valid_seen", 32'(valid_seen), 32'd0);

        // Reset during DATA_LO of register 1, then a clean restart.
        for (int i = 1; i <= 3; i++) mux_val[i] = 16'($urandom);
        build_exp(8'h5A, 16'h1234, 8'd3);
        cap.delete(); done_cnt = 0;
        @(posedge clk); #1;
        adr = 8'h5A; adr_first_reg_tx = 16'h1234; num_reg_tx = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && cap.size() < 8; cyc++) begin
            @(posedge clk); #1;
        end
        chk("rstmid_data_lo", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp_q[8]});
        reset = 1'b1;
        #1;
        chk("rstmid_outputs", {12'd0, selector, tx_data, tx_valid, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        run_frame(8'h5A, 16'h1234, 8'd3, 0, 1'b0, "restart");

        // Random frames against the model.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] rn;
            rn = 8'($urandom_range(1, 20));
            for (int i = 1; i <= 20; i++) mux_val[i] = 16'($urandom);
            run_frame(8'($urandom), 16'($urandom), rn, 2, 1'b0, $sformatf("rnd%0d", r));
        end

`ifdef MODBUS_TX_GAP_EN
        // Gap: start 5 cycles after done is ignored; busy falls 10 cycles after done.
        begin
            bit got;
            int fall;
            mux_val[1] = 16'hBEEF;
            rdy_mode = 0; err_cnt = 0;
            @(posedge clk); #1;
            adr = 8'h11; adr_first_reg_tx = 16'h0000; num_reg_tx = 8'd1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            got = 1'b0;
            for (int cyc = 0; cyc < 200 && !got; cyc++) begin
                @(posedge clk); #1;
                if (done) got = 1'b1;
            end
            chk("gap_done_seen", 32'(got), 32'd1);
            fall = -1;
            for (int j = 1; j <= 20; j++) begin
                @(posedge clk); #1;
                start = (j == 5);
                if (!busy && fall < 0) fall = j;
            end
            start = 1'b0;
            chk("gap_busy_fall", 32'(fall), 32'd10);
            chk("gap_start_ignored", 32'(busy), 32'd0);
            chk("gap_no_err", 32'(err_cnt), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
